// File: rtl/spi_audio_rx.sv
// rtl/spi_audio_rx.sv - oversampled SPI-slave audio word receiver.
// Optional flow control (audio_ack/overrun) when SPI_AUDIO_RX_HANDSHAKE_EN is defined.
module spi_audio_rx #(
  parameter int DATA_W      = 16,
  parameter int MSB_FIRST   = 1,
  parameter int SAMPLE_EDGE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              mosi_in,
  input  logic              active,
`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
  input  logic              audio_ack,
  output logic              overrun,
`endif
  output logic [DATA_W-1:0] audio_out,
  output logic              data_ready,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    RECEIVING
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, act_sync;
  logic sclk_s, mosi_s, act_s, sclk_d;
  logic edge_q, bit_q, act_q;

  logic [DATA_W-1:0] shift_q, shift_n, shifted, word_n, word_q;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              word_done, trunc, done_q, err_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign act_s  = act_sync[SYNC_STAGES-1];

  // Edge, data bit and frame enable are registered together so an edge and a
  // frame drop seen in the same cycle are handled in a fixed order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      act_sync  <= '0;
      sclk_d    <= 1'b0;
      edge_q    <= 1'b0;
      bit_q     <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      act_sync  <= {act_sync[SYNC_STAGES-2:0], active};
      sclk_d    <= sclk_s;
      edge_q    <= (SAMPLE_EDGE == 0) ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
      bit_q     <= mosi_s;
      act_q     <= act_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    cnt_n     = cnt_q;
    word_n    = shift_q;
    word_done = 1'b0;
    trunc     = 1'b0;
    shifted   = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], bit_q}
                                 : {bit_q, shift_q[DATA_W-1:1]};
    case (state)
      IDLE: begin
        shift_n = '0;
        cnt_n   = '0;
        if (act_q) state_n = RECEIVING;
      end
      RECEIVING: begin
        if (edge_q) begin
          if (cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            word_n    = shifted;
            shift_n   = '0;
            cnt_n     = '0;
          end else begin
            shift_n = shifted;
            cnt_n   = cnt_q + CNT_W'(1);
          end
        end
        // A non-zero count after this cycle's edge means a partial word.
        if (!act_q) begin
          trunc   = (cnt_n != '0);
          state_n = IDLE;
          shift_n = '0;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      shift_q   <= shift_n;
      cnt_q     <= cnt_n;
      done_q    <= word_done;
      err_q     <= trunc;
      busy      <= (state_n == RECEIVING);
      frame_err <= err_q;
      if (word_done) word_q <= word_n;
    end
  end

`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
  // data_ready is a level held until audio_ack; a new word while it is held
  // overwrites audio_out and flags overrun unless the ack lands in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_out  <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_q) begin
      audio_out  <= word_q;
      data_ready <= 1'b1;
      overrun    <= data_ready & ~audio_ack;
    end else begin
      overrun <= 1'b0;
      if (audio_ack) data_ready <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_out  <= '0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= done_q;
      if (done_q) audio_out <= word_q;
    end
  end
`endif

endmodule

// File: tb/tb_spi_audio_rx.sv
// tb/tb_spi_audio_rx.sv - randomized bench for spi_audio_rx against a word-level model.
// Unit A: 16-bit MSB-first rising edge; unit B: 24-bit LSB-first falling edge.
module tb_spi_audio_rx;

  localparam int S_A = 2;
  localparam int S_B = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  logic        a_sclk, a_mosi, a_act, a_ready, a_err, a_busy;
  logic [15:0] a_audio;
  logic        b_sclk, b_mosi, b_act, b_ready, b_err, b_busy;
  logic [23:0] b_audio;
`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
  logic a_ack, a_ovr, b_ack, b_ovr;
  int   ovr_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_cnt[2];
  int err_cnt[2];
  int exp_rdy[2];
  int exp_err[2];
  logic [31:0] last_word[2];
  logic [31:0] a_exp_q[$], b_exp_q[$];
  int          a_lat_q[$], b_lat_q[$];
  logic [31:0] wq[$];
  bit          a_mon_en = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_audio_rx #(.DATA_W(16), .MSB_FIRST(1), .SAMPLE_EDGE(0), .SYNC_STAGES(S_A)) u_a (
    .clk(clk), .reset(reset), .sclk_in(a_sclk), .mosi_in(a_mosi), .active(a_act),
`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
    .audio_ack(a_ack), .overrun(a_ovr),
`endif
    .audio_out(a_audio), .data_ready(a_ready), .frame_err(a_err), .busy(a_busy)
  );

  spi_audio_rx #(.DATA_W(24), .MSB_FIRST(0), .SAMPLE_EDGE(1), .SYNC_STAGES(S_B)) u_b (
    .clk(clk), .reset(reset), .sclk_in(b_sclk), .mosi_in(b_mosi), .active(b_act),
`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
    .audio_ack(b_ack), .overrun(b_ovr),
`endif
    .audio_out(b_audio), .data_ready(b_ready), .frame_err(b_err), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each word must appear once, carry the sent value, and arrive S+2 clocks after
  // the clock edge that first registers its last sampling transition.
  always @(negedge clk) begin
    if (!reset) begin
      check("a_ready_err_excl", {31'b0, a_ready & a_err}, 0);
      check("b_ready_err_excl", {31'b0, b_ready & b_err}, 0);
      if (a_ready && a_mon_en) begin
        rdy_cnt[0]++;
        check("a_word_pending", {31'b0, a_exp_q.size() != 0}, 1);
        if (a_exp_q.size() != 0) begin
          check("a_audio_out", a_audio, a_exp_q.pop_front());
          check("a_latency", cyc - a_lat_q.pop_front(), S_A + 2);
        end
      end
      if (b_ready) begin
        rdy_cnt[1]++;
        check("b_word_pending", {31'b0, b_exp_q.size() != 0}, 1);
        if (b_exp_q.size() != 0) begin
          check("b_audio_out", b_audio, b_exp_q.pop_front());
          check("b_latency", cyc - b_lat_q.pop_front(), S_B + 2);
        end
      end
      if (a_err) err_cnt[0]++;
      if (b_err) err_cnt[1]++;
`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
      if (a_ovr) ovr_cnt++;
`endif
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic sc, input logic mo, input logic ac);
    if (sel == 0) begin
      a_sclk = sc; a_mosi = mo; a_act = ac;
    end else begin
      b_sclk = sc; b_mosi = mo; b_act = ac;
    end
  endtask

  task automatic record(input int sel, input logic [31:0] w);
    if (sel == 0) begin
      a_exp_q.push_back(w); a_lat_q.push_back(cyc + 1);
    end else begin
      b_exp_q.push_back(w); b_lat_q.push_back(cyc + 1);
    end
    last_word[sel] = w;
  endtask

  // One bit: data set up, sclk high, sclk low; last=1 marks the word's final bit.
  task automatic send_bit(input int sel, input int h, input logic b, input bit last,
                          input logic [31:0] w);
    drive(sel, 1'b0, b, 1'b1);
    wait_clk(h);
    drive(sel, 1'b1, b, 1'b1);
    if (last && sel == 0) record(sel, w);
    wait_clk(h);
    drive(sel, 1'b0, b, 1'b1);
    if (last && sel == 1) record(sel, w);
    wait_clk(h);
  endtask

  function automatic logic nth_bit(input int sel, input logic [31:0] w, input int i);
    return (sel == 0) ? w[15 - i] : w[i];
  endfunction

  task automatic frame_checks(input int sel, input string tag);
    check({tag, "_ready_count"}, rdy_cnt[sel], exp_rdy[sel]);
    check({tag, "_err_count"}, err_cnt[sel], exp_err[sel]);
    check({tag, "_queue_drained"}, (sel == 0) ? a_exp_q.size() : b_exp_q.size(), 0);
    check({tag, "_audio_hold"}, (sel == 0) ? {16'b0, a_audio} : {8'b0, b_audio},
          last_word[sel]);
    check({tag, "_idle"}, {31'b0, (sel == 0) ? a_busy : b_busy}, 0);
  endtask

  // Sends every word in wq, then pbits leading bits of pword, then drops active.
  task automatic send_frame(input int sel, input int h, input int pbits,
                            input logic [31:0] pword, input string tag);
    int dw;
    dw = (sel == 0) ? 16 : 24;
    drive(sel, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    check({tag, "_busy"}, {31'b0, (sel == 0) ? a_busy : b_busy}, 1);
    foreach (wq[k]) begin
      for (int i = 0; i < dw; i++) send_bit(sel, h, nth_bit(sel, wq[k], i), i == dw - 1, wq[k]);
      check({tag, "_busy_word"}, {31'b0, (sel == 0) ? a_busy : b_busy}, 1);
    end
    for (int i = 0; i < pbits; i++) send_bit(sel, h, nth_bit(sel, pword, i), 1'b0, pword);
    drive(sel, 1'b0, 1'b0, 1'b0);
    exp_rdy[sel] += wq.size();
    if (pbits % dw != 0) exp_err[sel] += 1;
    wait_clk(12);
    frame_checks(sel, tag);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rdy_cnt[s] = 0; err_cnt[s] = 0; exp_rdy[s] = 0; exp_err[s] = 0; last_word[s] = '0;
    end
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
    a_ack = 1'b1; b_ack = 1'b1;
`endif
    wait_clk(4);
    check("rst_a_audio", a_audio, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_a_err", a_err, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_b_audio", b_audio, 0);
    check("rst_b_busy", b_busy, 0);
    reset = 1'b0;
    wait_clk(6);

    wq = '{32'hA5C3};
    send_frame(0, 4, 0, 0, "single");
    wq = '{32'h1234, 32'hFFFF};
    send_frame(0, 3, 0, 0, "b2b");
    wq = '{};
    send_frame(0, 3, 7, 32'hBEEF, "trunc7");

    // Reset in the middle of a word: no strobe, everything back to zero.
    drive(0, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    for (int i = 0; i < 9; i++) send_bit(0, 3, nth_bit(0, 32'hC3A5, i), 1'b0, 0);
    reset = 1'b1;
    wait_clk(2);
    check("midrst_a_audio", a_audio, 0);
    check("midrst_a_ready", a_ready, 0);
    check("midrst_a_err", a_err, 0);
    check("midrst_a_busy", a_busy, 0);
    check("midrst_b_audio", b_audio, 0);
    reset = 1'b0;
    last_word[0] = '0;
    last_word[1] = '0;
    wait_clk(10);
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_clk(12);
    frame_checks(0, "post_rst");
    wq = '{32'h00FF};
    send_frame(0, 3, 0, 0, "after_rst");

    wq = '{32'h800001};
    send_frame(1, 3, 0, 0, "w24_lsb");

    for (int r = 0; r < 8; r++) begin
      int sel, dw, nw, pb;
      sel = r % 2;
      dw  = (sel == 0) ? 16 : 24;
      nw  = $urandom_range(0, 3);
      pb  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, dw - 1) : 0;
      if (nw == 0 && pb == 0) nw = 1;
      wq = '{};
      for (int k = 0; k < nw; k++) wq.push_back($urandom() & ((sel == 0) ? 32'hFFFF : 32'hFF_FFFF));
      send_frame(sel, $urandom_range(2, 4), pb, $urandom(), "rand");
    end

`ifdef SPI_AUDIO_RX_HANDSHAKE_EN
    a_mon_en = 1'b0;
    a_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    for (int i = 0; i < 16; i++) send_bit(0, 3, nth_bit(0, 32'h0001, i), 1'b0, 0);
    for (int i = 0; i < 16; i++) send_bit(0, 3, nth_bit(0, 32'h0002, i), 1'b0, 0);
    wait_clk(10);
    check("hs_overrun_count", ovr_cnt, 1);
    check("hs_audio", a_audio, 32'h0002);
    check("hs_ready_held", a_ready, 1);
    a_ack = 1'b1;
    wait_clk(1);
    check("hs_ready_dropped", a_ready, 0);
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_clk(12);
    a_mon_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
